// File: rtl/cb_crc32_chk.sv
// Receive-side CRC32 frame checker: strips the 4-byte FCS, forwards payload, reports pass/fail.
// Optional saturating frame statistics when CRC_CHK_STAT_EN is defined.
module cb_crc32_chk #(
  parameter int U_DLY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [7:0]       src_data,
  input  logic             src_data_valid,
  input  logic             src_sof,
  input  logic             src_eof,
  output logic [7:0]       dst_data,
  output logic             dst_data_valid,
  output logic             dst_sof,
  output logic             dst_eof,
  output logic             chk_done,
  output logic             chk_err,
  output logic             chk_runt,
  output logic             chk_abort,
  output logic [31:0]      chk_crc_rx,
  output logic [31:0]      chk_crc_calc,
  output logic [CNT_W-1:0] frm_ok_cnt,
  output logic [CNT_W-1:0] frm_err_cnt
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  if (U_DLY < 0 || CNT_W < 1) begin : g_bad_param
    $error("cb_crc32_chk: bad parameter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PASS
  } state_t;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] sr_q, sr_d;
  logic        first_q, first_d;

  logic [31:0] crc_nxt, fcs;
  logic [7:0]  data_d;
  logic        vld_d, sof_d, eof_d;
  logic        done_d, err_d, runt_d, abort_d;
  logic [31:0] rx_d, calc_d;

  // sr_q packs sr3..sr0 as [31:24]..[7:0]
  assign crc_nxt = crc_byte(crc_q, sr_q[31:24]);
  assign fcs     = {sr_q[23:0], src_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    sr_d    = sr_q;
    first_d = first_q;
    data_d  = dst_data;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    runt_d  = 1'b0;
    abort_d = 1'b0;
    rx_d    = chk_crc_rx;
    calc_d  = chk_crc_calc;
    if (src_data_valid && src_sof) begin
      if (state_q != S_IDLE) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        abort_d = 1'b1;
      end
      if (src_eof) begin
        done_d = 1'b1;
        err_d  = 1'b1;
        runt_d = 1'b1;
      end
      if (done_d) begin
        rx_d   = fcs;
        calc_d = crc_q;
      end
      state_d = src_eof ? S_IDLE : S_FILL;
      cnt_d   = 3'd1;
      crc_d   = '1;
      sr_d    = {24'h0, src_data};
      first_d = 1'b1;
    end else if (src_data_valid) begin
      unique case (state_q)
        S_IDLE: ;
        S_FILL: begin
          sr_d = {sr_q[23:0], src_data};
          if (src_eof) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            runt_d  = 1'b1;
            rx_d    = fcs;
            calc_d  = crc_q;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = S_PASS;
          end
        end
        S_PASS: begin
          vld_d   = 1'b1;
          data_d  = sr_q[31:24];
          sof_d   = first_q;
          first_d = 1'b0;
          crc_d   = crc_nxt;
          sr_d    = {sr_q[23:0], src_data};
          if (src_eof) begin
            eof_d   = 1'b1;
            done_d  = 1'b1;
            err_d   = (crc_nxt != fcs);
            rx_d    = fcs;
            calc_d  = crc_nxt;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      crc_q          <= '1;
      sr_q           <= '0;
      first_q        <= 1'b0;
      dst_data       <= '0;
      dst_data_valid <= 1'b0;
      dst_sof        <= 1'b0;
      dst_eof        <= 1'b0;
      chk_done       <= 1'b0;
      chk_err        <= 1'b0;
      chk_runt       <= 1'b0;
      chk_abort      <= 1'b0;
      chk_crc_rx     <= '0;
      chk_crc_calc   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      crc_q          <= crc_d;
      sr_q           <= sr_d;
      first_q        <= first_d;
      dst_data       <= data_d;
      dst_data_valid <= vld_d;
      dst_sof        <= sof_d;
      dst_eof        <= eof_d;
      chk_done       <= done_d;
      chk_err        <= err_d;
      chk_runt       <= runt_d;
      chk_abort      <= abort_d;
      chk_crc_rx     <= rx_d;
      chk_crc_calc   <= calc_d;
    end
  end

`ifdef CRC_CHK_STAT_EN
  logic [CNT_W-1:0] ok_cnt_q, err_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (done_d) begin
      if (err_d) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end else begin
        if (ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + 1'b1;
      end
    end
  end

  assign frm_ok_cnt  = ok_cnt_q;
  assign frm_err_cnt = err_cnt_q;
`else
  assign frm_ok_cnt  = '0;
  assign frm_err_cnt = '0;
`endif

endmodule

// File: tb/tb_cb_crc32_chk.sv
// Randomized self-checking bench for cb_crc32_chk against a frame-level model.
// Statistics checks follow CRC_CHK_STAT_EN.
module tb_cb_crc32_chk;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  src_data;
  logic        src_data_valid, src_sof, src_eof;
  logic [7:0]  dst_data;
  logic        dst_data_valid, dst_sof, dst_eof;
  logic        chk_done, chk_err, chk_runt, chk_abort;
  logic [31:0] chk_crc_rx, chk_crc_calc;
  logic [15:0] frm_ok_cnt, frm_err_cnt;

  cb_crc32_chk #(.U_DLY(1), .CNT_W(16)) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .src_data       (src_data),
    .src_data_valid (src_data_valid),
    .src_sof        (src_sof),
    .src_eof        (src_eof),
    .dst_data       (dst_data),
    .dst_data_valid (dst_data_valid),
    .dst_sof        (dst_sof),
    .dst_eof        (dst_eof),
    .chk_done       (chk_done),
    .chk_err        (chk_err),
    .chk_runt       (chk_runt),
    .chk_abort      (chk_abort),
    .chk_crc_rx     (chk_crc_rx),
    .chk_crc_calc   (chk_crc_calc),
    .frm_ok_cnt     (frm_ok_cnt),
    .frm_err_cnt    (frm_err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       sof;
    logic       eof;
    logic [7:0] d;
    int         cyc;
  } out_t;

  typedef struct {
    logic        err;
    logic        runt;
    logic        abort;
    logic        has_crc;
    logic [31:0] rx;
    logic [31:0] calc;
    int          cyc;
  } rep_t;

  out_t       got_out[$], exp_out[$];
  rep_t       got_rep[$], exp_rep[$];
  logic [7:0] fb[$];
  int         cyc = 0;
  int         last_cyc;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_ok = 0;
  int         exp_bad = 0;
  logic       pend_abort = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (rst === 1'b0) begin
      if (dst_data_valid)
        got_out.push_back('{dst_sof, dst_eof, dst_data, cyc});
      if (chk_done)
        got_rep.push_back('{chk_err, chk_runt, chk_abort, 1'b0,
                            chk_crc_rx, chk_crc_calc, cyc});
      else
        check("flags_idle", {29'h0, chk_err, chk_runt, chk_abort}, 32'h0);
    end
  end

  // CRC straight from its definition: one bit at a time, bit 0 of each byte first
  function automatic logic [31:0] ref_crc(input int m);
    logic [31:0] c;
    logic        b, msb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < 8; j++) begin
        b   = fb[i][j];
        msb = c[31];
        c   = c << 1;
        if (msb ^ b) c = c ^ 32'h04C1_1DB7;
      end
    return c;
  endfunction

  task automatic note_rep(input logic err);
    if (err) exp_bad = (exp_bad >= 65535) ? 65535 : exp_bad + 1;
    else     exp_ok  = (exp_ok  >= 65535) ? 65535 : exp_ok + 1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s,
                            input logic e, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (g) begin
      @(negedge clk_sys);
      src_data_valid = 1'b0;
      src_data       = 8'($urandom);
      src_sof        = 1'($urandom_range(0, 1));
      src_eof        = 1'($urandom_range(0, 1));
    end
    @(negedge clk_sys);
    src_data_valid = 1'b1;
    src_data       = d;
    src_sof        = s;
    src_eof        = e;
    last_cyc       = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      src_data_valid = 1'b0;
      src_sof        = 1'b0;
      src_eof        = 1'b0;
    end
  endtask

  // Sends fb as one frame and queues what the model expects from it
  task automatic send_frame(input int gmax);
    int          n;
    int          cq[$];
    logic [31:0] c, rx;
    n = fb.size();
    for (int i = 0; i < n; i++) begin
      drive_byte(fb[i], i == 0, i == n - 1, (i == 0) ? 0 : gmax);
      cq.push_back(last_cyc);
      if (i == 0 && pend_abort && n > 1) begin
        exp_rep.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, cq[0] + 1});
        note_rep(1'b1);
        pend_abort = 1'b0;
      end
    end
    if (pend_abort) begin
      exp_rep.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, cq[0] + 1});
      note_rep(1'b1);
      pend_abort = 1'b0;
    end else if (n < 5) begin
      exp_rep.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, cq[n-1] + 1});
      note_rep(1'b1);
    end else begin
      for (int k = 0; k < n - 4; k++)
        exp_out.push_back('{k == 0, k == n - 5, fb[k], cq[k+4] + 1});
      c  = ref_crc(n - 4);
      rx = {fb[n-4], fb[n-3], fb[n-2], fb[n-1]};
      exp_rep.push_back('{c != rx, 1'b0, 1'b0, 1'b1, rx, c, cq[n-1] + 1});
      note_rep(c != rx);
    end
  endtask

  task automatic build_rand(input int lo, input int hi, input logic corrupt);
    int          n, k;
    logic [31:0] c;
    n = $urandom_range(lo, hi);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    if (n >= 5) begin
      c = ref_crc(n - 4);
      fb[n-4] = c[31:24];
      fb[n-3] = c[23:16];
      fb[n-2] = c[15:8];
      fb[n-1] = c[7:0];
      if (corrupt && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, n - 1);
        fb[k] = fb[k] ^ 8'(1 << $urandom_range(0, 7));
      end
    end
  endtask

  task automatic flush();
    int n;
    idle(8);
    check("n_out", got_out.size(), exp_out.size());
    n = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
    for (int i = 0; i < n; i++) begin
      check("out_data", {24'h0, got_out[i].d}, {24'h0, exp_out[i].d});
      check("out_sof_eof", {30'h0, got_out[i].sof, got_out[i].eof},
            {30'h0, exp_out[i].sof, exp_out[i].eof});
      check("out_cycle", got_out[i].cyc, exp_out[i].cyc);
    end
    check("n_rep", got_rep.size(), exp_rep.size());
    n = (got_rep.size() < exp_rep.size()) ? got_rep.size() : exp_rep.size();
    for (int i = 0; i < n; i++) begin
      check("rep_flags",
            {29'h0, got_rep[i].err, got_rep[i].runt, got_rep[i].abort},
            {29'h0, exp_rep[i].err, exp_rep[i].runt, exp_rep[i].abort});
      check("rep_cycle", got_rep[i].cyc, exp_rep[i].cyc);
      if (exp_rep[i].has_crc) begin
        check("crc_rx", got_rep[i].rx, exp_rep[i].rx);
        check("crc_calc", got_rep[i].calc, exp_rep[i].calc);
      end
    end
`ifdef CRC_CHK_STAT_EN
    check("ok_cnt", {16'h0, frm_ok_cnt}, exp_ok);
    check("err_cnt", {16'h0, frm_err_cnt}, exp_bad);
`else
    check("ok_cnt_tied", {16'h0, frm_ok_cnt}, 32'h0);
    check("err_cnt_tied", {16'h0, frm_err_cnt}, 32'h0);
`endif
    got_out.delete();
    exp_out.delete();
    got_rep.delete();
    exp_rep.delete();
  endtask

  initial begin
    rst            = 1'b1;
    src_data       = 8'h0;
    src_data_valid = 1'b0;
    src_sof        = 1'b0;
    src_eof        = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_vld", {31'h0, dst_data_valid}, 32'h0);
    check("rst_data", {24'h0, dst_data}, 32'h0);
    check("rst_sof_eof", {30'h0, dst_sof, dst_eof}, 32'h0);
    check("rst_done", {31'h0, chk_done}, 32'h0);
    check("rst_crc_rx", chk_crc_rx, 32'h0);
    check("rst_crc_calc", chk_crc_calc, 32'h0);
    check("rst_cnts", {frm_ok_cnt, frm_err_cnt}, 32'h0);
    rst = 1'b0;
    idle(2);

    fb = '{8'h00, 8'h4E, 8'h08, 8'hBF, 8'hB4};
    send_frame(0);
    flush();

    fb = '{8'h00, 8'h4E, 8'h08, 8'hBF, 8'hB5};
    send_frame(0);
    flush();
    check("crc_rx_held", chk_crc_rx, 32'h4E08_BFB5);

    fb = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(2);
    fb = '{8'h5A};
    send_frame(0);
    flush();

    repeat (6) begin
      build_rand(5, 24, 1'b0);
      send_frame(3);
      build_rand(5, 24, 1'b0);
      send_frame(0);
    end
    flush();

    repeat (25) begin
      build_rand(1, 24, 1'b1);
      send_frame($urandom_range(0, 2));
    end
    flush();

    drive_byte(8'hA0, 1'b1, 1'b0, 0);
    drive_byte(8'hA1, 1'b0, 1'b0, 0);
    drive_byte(8'hA2, 1'b0, 1'b0, 0);
    pend_abort = 1'b1;
    fb = '{8'h00, 8'h4E, 8'h08, 8'hBF, 8'hB4};
    send_frame(0);
    flush();

    drive_byte(8'h11, 1'b1, 1'b0, 0);
    drive_byte(8'h22, 1'b0, 1'b0, 0);
    pend_abort = 1'b1;
    fb = '{8'h77};
    send_frame(0);
    flush();

    drive_byte(8'h31, 1'b1, 1'b0, 0);
    drive_byte(8'h32, 1'b0, 1'b0, 0);
    @(negedge clk_sys);
    rst            = 1'b1;
    src_data_valid = 1'b0;
    @(negedge clk_sys);
    rst     = 1'b0;
    exp_ok  = 0;
    exp_bad = 0;
    drive_byte(8'h33, 1'b0, 1'b0, 0);
    drive_byte(8'h34, 1'b0, 1'b1, 1);
    drive_byte(8'h35, 1'b0, 1'b0, 0);
    build_rand(5, 16, 1'b0);
    send_frame(2);
    flush();

`ifdef CRC_CHK_STAT_EN
    @(negedge clk_sys);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk_sys);
    release dut.err_cnt_q;
    exp_bad = 65535;
    fb = '{8'h00, 8'h4E, 8'h08, 8'hBF, 8'hB5};
    send_frame(0);
    flush();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
